// File: rtl/musa_chk_pkg.sv
// musa_chk_pkg: control-vector layout, per-opcode expected control patterns and opcode decode
package musa_chk_pkg;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h01;
    localparam logic [5:0] OP_SW    = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h03;
    localparam logic [5:0] OP_SUBI  = 6'h04;
    localparam logic [5:0] OP_ANDI  = 6'h05;
    localparam logic [5:0] OP_ORI   = 6'h06;
    localparam logic [5:0] OP_JPC   = 6'h07;
    localparam logic [5:0] OP_BRFL  = 6'h08;
    localparam logic [5:0] OP_JR    = 6'h09;
    localparam logic [5:0] OP_CALL  = 6'h0A;
    localparam logic [5:0] OP_RET   = 6'h0B;
    localparam logic [5:0] OP_HALT  = 6'h0C;

    typedef struct packed {
        logic       reg_dst;
        logic       mem_read;
        logic       mem_to_reg;
        logic [2:0] alu_op;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] data_a_s;
        logic [1:0] data_b_s;
        logic [2:0] pc_src;
        logic       pop;
        logic       push;
    } ctrl_vec_t;

    typedef enum logic [3:0] {
        R_SW, R_LW, R_IMM, R_JPC, R_BRFL, R_JR, R_CALL, R_RET, R_RTYPE, R_HALT
    } rule_id_e;

    typedef struct packed {
        ctrl_vec_t mask;
        ctrl_vec_t value;
    } rule_t;

    typedef struct packed {
        logic     hit;
        rule_id_e id;
    } decode_t;

    // bit groups: {rd,mr,mtr}_{alu_op}_{mw,rw}_{a_s}_{b_s}_{pc_src}_{pop,push}
    localparam rule_t RULE_TABLE [10] = '{
        '{17'b000_000_10_11_00_111_00, 17'b000_000_10_10_00_010_00},
        '{17'b010_000_01_00_00_111_00, 17'b010_000_01_00_00_010_00},
        '{17'b000_000_01_11_00_111_00, 17'b000_000_01_10_00_010_00},
        '{17'b000_000_00_00_11_111_00, 17'b000_000_00_00_01_100_00},
        '{17'b000_111_00_11_00_111_00, 17'b000_101_00_10_00_001_00},
        '{17'b000_000_00_00_00_111_00, 17'b000_000_00_00_00_001_00},
        '{17'b000_000_00_00_00_111_01, 17'b000_000_00_00_00_001_01},
        '{17'b000_000_00_00_00_111_10, 17'b000_000_00_00_00_000_10},
        '{17'b100_111_01_11_11_111_00, 17'b100_010_01_10_01_010_00},
        '{17'b000_000_00_00_00_111_00, 17'b000_000_00_00_00_110_00}
    };

    function automatic decode_t decode_rule(input logic [5:0] op);
        decode_t d;
        d = '{hit: 1'b1, id: R_HALT};
        case (op)
            OP_SW:                             d.id = R_SW;
            OP_LW:                             d.id = R_LW;
            OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI: d.id = R_IMM;
            OP_JPC:                            d.id = R_JPC;
            OP_BRFL:                           d.id = R_BRFL;
            OP_JR:                             d.id = R_JR;
            OP_CALL:                           d.id = R_CALL;
            OP_RET:                            d.id = R_RET;
            OP_RTYPE:                          d.id = R_RTYPE;
            OP_HALT:                           d.id = R_HALT;
            default:                           d.hit = 1'b0;
        endcase
        return d;
    endfunction
endpackage

// File: rtl/musa_chk_slot.sv
// musa_chk_slot: one outstanding check, ageing each cycle and resolving to pass or fail inside its window
module musa_chk_slot
    import musa_chk_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int WIN_MIN    = 1,
    parameter int WIN_MAX    = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_i,
    input  logic                  alloc_i,
    input  rule_id_e              rule_i,
    input  logic [DATA_WIDTH-1:0] instr_i,
    input  ctrl_vec_t             ctrl_i,
    output logic                  busy_o,
    output logic                  busy_d_o,
    output logic                  pass_o,
    output logic                  fail_o,
    output rule_id_e              rule_o,
    output logic [DATA_WIDTH-1:0] instr_o
);
    logic                  busy_q;
    logic [3:0]            age_q, age_d;
    rule_id_e              rule_q;
    logic [DATA_WIDTH-1:0] instr_q;
    logic                  hit, in_win;

    assign age_d    = age_q + 4'd1;
    assign hit      = (ctrl_i & RULE_TABLE[rule_q].mask) == RULE_TABLE[rule_q].value;
    assign in_win   = age_d >= 4'(WIN_MIN) && age_d <= 4'(WIN_MAX);
    assign pass_o   = busy_q && in_win && hit;
    assign fail_o   = busy_q && !pass_o && age_d == 4'(WIN_MAX);
    assign busy_d_o = alloc_i | (busy_q & ~pass_o & ~fail_o);
    assign busy_o   = busy_q;
    assign rule_o   = rule_q;
    assign instr_o  = instr_q;

    always_ff @(posedge clk) begin
        if (!rst_n || clr_i) begin
            busy_q  <= 1'b0;
            age_q   <= '0;
            rule_q  <= R_SW;
            instr_q <= '0;
        end else if (alloc_i) begin
            busy_q  <= 1'b1;
            age_q   <= '0;
            rule_q  <= rule_i;
            instr_q <= instr_i;
        end else begin
            busy_q  <= busy_d_o;
            age_q   <= age_d;
        end
    end
endmodule

// File: rtl/musa_ctrl_checker.sv
// musa_ctrl_checker: passive checker that each decoded instruction's control pattern appears within its window
module musa_ctrl_checker
    import musa_chk_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int MAX_PENDING = 4,
    parameter int WIN_MIN     = 1,
    parameter int WIN_MAX     = 5,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               en_i,
    input  logic                               clr_i,
    input  logic                               instr_valid_i,
    input  logic [DATA_WIDTH-1:0]              instruction_i,
    input  logic                               reg_dst_i,
    input  logic                               mem_read_i,
    input  logic                               mem_to_reg_i,
    input  logic                               mem_write_i,
    input  logic                               reg_write_i,
    input  logic                               pop_i,
    input  logic                               push_i,
    input  logic [2:0]                         alu_op_i,
    input  logic [1:0]                         data_a_s_i,
    input  logic [1:0]                         data_b_s_i,
    input  logic [2:0]                         pc_src_i,
    output logic [CNT_WIDTH-1:0]               pass_cnt_o,
    output logic [CNT_WIDTH-1:0]               fail_cnt_o,
    output logic [CNT_WIDTH-1:0]               drop_cnt_o,
    output logic [$clog2(MAX_PENDING+1)-1:0]   pending_cnt_o,
    output logic                               err_valid_o,
    output logic [3:0]                         err_rule_o,
    output logic [DATA_WIDTH-1:0]              err_instr_o,
    output logic                               err_sticky_o
);
    localparam int PW  = $clog2(MAX_PENDING + 1);
    localparam int CW1 = CNT_WIDTH + 1;

    ctrl_vec_t              ctrl;
    decode_t                dec;
    logic [MAX_PENDING-1:0] busy, busy_d, pass, fail, free, alloc;
    rule_id_e               rule_s [MAX_PENDING];
    logic [DATA_WIDTH-1:0]  instr_s [MAX_PENDING];
    logic                   want, drop;
    rule_id_e               err_rule_d, err_rule_q;
    logic [DATA_WIDTH-1:0]  err_instr_d, err_instr_q;
    logic [CNT_WIDTH:0]     pass_sum, fail_sum, drop_sum;
    logic [CNT_WIDTH-1:0]   pass_cnt_q, fail_cnt_q, drop_cnt_q;
    logic [PW-1:0]          pending_q;
    logic                   err_valid_q, err_sticky_q;

    assign ctrl  = {reg_dst_i, mem_read_i, mem_to_reg_i, alu_op_i, mem_write_i, reg_write_i,
                    data_a_s_i, data_b_s_i, pc_src_i, pop_i, push_i};
    assign dec   = decode_rule(instruction_i[31:26]);
    assign want  = en_i & instr_valid_i & dec.hit;
    assign free  = ~busy;
    // lowest set bit of the free mask picks the lowest-index free slot
    assign alloc = want ? (free & (-free)) : '0;
    assign drop  = want & ~(|free);

    for (genvar g = 0; g < MAX_PENDING; g++) begin : g_slot
        musa_chk_slot #(
            .DATA_WIDTH(DATA_WIDTH),
            .WIN_MIN   (WIN_MIN),
            .WIN_MAX   (WIN_MAX)
        ) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .clr_i   (clr_i),
            .alloc_i (alloc[g]),
            .rule_i  (dec.id),
            .instr_i (instruction_i),
            .ctrl_i  (ctrl),
            .busy_o  (busy[g]),
            .busy_d_o(busy_d[g]),
            .pass_o  (pass[g]),
            .fail_o  (fail[g]),
            .rule_o  (rule_s[g]),
            .instr_o (instr_s[g])
        );
    end

    always_comb begin
        err_rule_d  = R_SW;
        err_instr_d = '0;
        for (int i = MAX_PENDING - 1; i >= 0; i--) begin
            err_rule_d  = fail[i] ? rule_s[i] : err_rule_d;
            err_instr_d = fail[i] ? instr_s[i] : err_instr_d;
        end
    end

    assign pass_sum = {1'b0, pass_cnt_q} + CW1'($countones(pass));
    assign fail_sum = {1'b0, fail_cnt_q} + CW1'($countones(fail));
    assign drop_sum = {1'b0, drop_cnt_q} + CW1'(drop);

    always_ff @(posedge clk) begin
        if (!rst_n || clr_i) begin
            pass_cnt_q   <= '0;
            fail_cnt_q   <= '0;
            drop_cnt_q   <= '0;
            pending_q    <= '0;
            err_valid_q  <= 1'b0;
            err_rule_q   <= R_SW;
            err_instr_q  <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            pass_cnt_q   <= pass_sum[CNT_WIDTH] ? '1 : pass_sum[CNT_WIDTH-1:0];
            fail_cnt_q   <= fail_sum[CNT_WIDTH] ? '1 : fail_sum[CNT_WIDTH-1:0];
            drop_cnt_q   <= drop_sum[CNT_WIDTH] ? '1 : drop_sum[CNT_WIDTH-1:0];
            pending_q    <= PW'($countones(busy_d));
            err_valid_q  <= |fail;
            err_rule_q   <= (|fail) ? err_rule_d : err_rule_q;
            err_instr_q  <= (|fail) ? err_instr_d : err_instr_q;
            err_sticky_q <= err_sticky_q | (|fail);
        end
    end

    assign pass_cnt_o    = pass_cnt_q;
    assign fail_cnt_o    = fail_cnt_q;
    assign drop_cnt_o    = drop_cnt_q;
    assign pending_cnt_o = pending_q;
    assign err_valid_o   = err_valid_q;
    assign err_rule_o    = err_rule_q;
    assign err_instr_o   = err_instr_q;
    assign err_sticky_o  = err_sticky_q;
endmodule
